// File: rtl/lvds_tx_framer_if.sv
//==============================================================================
// Module      : lvds_tx_framer_if
// Description : Sample-input and TX-FIFO write-side bundle for lvds_tx_framer.
//               slave  - framer view: receives samples and FIFO full, drives
//                        ready and the FIFO write data and strobe.
//               master - host/FIFO view: opposite directions.
//               Signals: i_sample_i[12:0], i_sample_q[12:0], i_sample_ctrl,
//                        i_sample_valid, o_sample_ready, o_fifo_data[31:0],
//                        o_fifo_push, i_fifo_full.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface lvds_tx_framer_if;
  logic [12:0] i_sample_i;
  logic [12:0] i_sample_q;
  logic        i_sample_ctrl;
  logic        i_sample_valid;
  logic        o_sample_ready;
  logic [31:0] o_fifo_data;
  logic        o_fifo_push;
  logic        i_fifo_full;

  modport slave (
    input  i_sample_i,
    input  i_sample_q,
    input  i_sample_ctrl,
    input  i_sample_valid,
    output o_sample_ready,
    output o_fifo_data,
    output o_fifo_push,
    input  i_fifo_full
  );

  modport master (
    output i_sample_i,
    output i_sample_q,
    output i_sample_ctrl,
    output i_sample_valid,
    input  o_sample_ready,
    input  o_fifo_data,
    input  o_fifo_push,
    output i_fifo_full
  );
endinterface

`default_nettype wire

// File: rtl/lvds_tx_framer.sv
//==============================================================================
// Module      : lvds_tx_framer
// Description : Packs 13-bit I/Q sample pairs into 32-bit radio frame words
//               {2'b10, I, 1'b0, 2'b01, Q, C} and writes them into the TX FIFO.
//               Each burst is bracketed by PREAMBLE_LEN and TAIL_LEN zero
//               frames (32'h8000_4000).
//               Ports: i_sys_clk, i_rst (sync, active high), i_tx_en (burst
//               level), bus (lvds_tx_framer_if.slave: samples + FIFO write
//               side), o_tx_busy, o_debug_state (IDLE=0 PREAMBLE=1 STREAM=2
//               TAIL=3).
//               Optional macro TX_FRAMER_CTRL_EN: frame bit 0 carries
//               i_sample_ctrl of the accepted sample.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lvds_tx_framer #(
  parameter int PREAMBLE_LEN = 4,
  parameter int TAIL_LEN     = 4
) (
  input  wire logic        i_sys_clk,
  input  wire logic        i_rst,
  input  wire logic        i_tx_en,
  lvds_tx_framer_if.slave  bus,
  output logic             o_tx_busy,
  output logic [1:0]       o_debug_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_STREAM   = 2'd2,
    ST_TAIL     = 2'd3
  } state_t;

  localparam logic [31:0] C_ZERO_FRAME = 32'h8000_4000;
  localparam logic [7:0]  C_PRE_LAST   = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  C_TAIL_LEN   = 8'(TAIL_LEN);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic        w_push;
  logic        w_slot;
  logic        w_ready;
  logic        w_load;
  logic [31:0] w_load_data;
  logic        w_ctrl;
  logic [31:0] w_frame;

`ifdef TX_FRAMER_CTRL_EN
  assign w_ctrl = bus.i_sample_ctrl;
`else
  logic w_unused_ctrl;
  assign w_unused_ctrl = bus.i_sample_ctrl;
  assign w_ctrl        = 1'b0;
`endif

  assign w_frame = {2'b10, bus.i_sample_i, 1'b0, 2'b01, bus.i_sample_q, w_ctrl};

  // Push whenever a word is held and the FIFO can take it; the holding
  // register may reload in the same cycle it pushes, giving 1 word/clk.
  assign w_push = out_valid_q & ~bus.i_fifo_full & ~i_rst;
  assign w_slot = ~out_valid_q | w_push;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_load      = 1'b0;
    w_load_data = C_ZERO_FRAME;
    w_ready     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_tx_en) begin
          state_d = ST_PREAMBLE;
          cnt_d   = 8'd0;
        end
      end
      ST_PREAMBLE: begin
        // Enable is deliberately ignored: the preamble always completes.
        if (w_slot) begin
          w_load = 1'b1;
          if (cnt_q == C_PRE_LAST) begin
            state_d = ST_STREAM;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_STREAM: begin
        if (!i_tx_en) begin
          state_d = ST_TAIL;
          cnt_d   = 8'd0;
        end else begin
          w_ready = w_slot & ~i_rst;
          if (bus.i_sample_valid && w_ready) begin
            w_load      = 1'b1;
            w_load_data = w_frame;
          end
        end
      end
      ST_TAIL: begin
        // After the last tail load, stay here until that word has left.
        if (cnt_q != C_TAIL_LEN) begin
          if (w_slot) begin
            w_load = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end
        end else if (!out_valid_q) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    out_data_d  = w_load ? w_load_data : out_data_q;
    out_valid_d = w_load ? 1'b1 : (w_push ? 1'b0 : out_valid_q);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      out_data_q  <= C_ZERO_FRAME;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.o_fifo_data    = out_data_q;
  assign bus.o_fifo_push    = w_push;
  assign bus.o_sample_ready = w_ready;
  // Status is forced to idle while reset is asserted, not only after it.
  assign o_tx_busy          = (state_q != ST_IDLE) & ~i_rst;
  assign o_debug_state      = i_rst ? 2'd0 : state_q;

endmodule

`default_nettype wire

// File: tb/tb_lvds_tx_framer.sv
//==============================================================================
// Module      : tb_lvds_tx_framer
// Description : Scoreboard bench for lvds_tx_framer (PREAMBLE_LEN=2,
//               TAIL_LEN=2). Stimulus pushes expected frame words into a
//               queue; a negedge monitor pops and compares on every push.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lvds_tx_framer;
  localparam int PRE  = 2;
  localparam int TAIL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       busy;
  logic [1:0] dbg;

  always #5 clk = ~clk;

  lvds_tx_framer_if bus ();

  lvds_tx_framer #(.PREAMBLE_LEN(PRE), .TAIL_LEN(TAIL)) u_dut (
    .i_sys_clk     (clk),
    .i_rst         (rst),
    .i_tx_en       (tx_en),
    .bus           (bus.slave),
    .o_tx_busy     (busy),
    .o_debug_state (dbg)
  );

  int          total = 0;
  int          bad   = 0;
  int          push_cnt = 0;
  bit          rand_full = 1'b0;
  logic [31:0] exp_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endfunction

  // Frame layout from the field positions: I at bits 29:17, Q at 13:1.
  function automatic logic [31:0] model_frame(logic [12:0] si, logic [12:0] sq, logic c);
    logic [31:0] w;
    w = 32'h8000_4000 | (32'(si) << 17) | (32'(sq) << 1);
`ifdef TX_FRAMER_CTRL_EN
    w = w | 32'(c);
`endif
    return w;
  endfunction

  // Monitor: every push must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.o_fifo_push) begin
      push_cnt++;
      if (bus.i_fifo_full) chk("push_while_full", 32'd1, 32'd0);
      if (exp_q.size() == 0) chk("unexpected_push", bus.o_fifo_data, 32'hxxxx_xxxx);
      else chk("frame", bus.o_fifo_data, exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rand_full) begin
      #1;
      bus.i_fifo_full = ($urandom_range(0, 99) < 30);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst();
    tx_en = 1'b1;
    for (int k = 0; k < PRE; k++) exp_q.push_back(32'h8000_4000);
  endtask

  task automatic send_sample(input logic [12:0] si, input logic [12:0] sq, input logic c, input int gap);
    bit acc = 1'b0;
    if (gap > 0) begin
      bus.i_sample_valid = 1'b0;
      repeat (gap) tick();
    end
    bus.i_sample_i     = si;
    bus.i_sample_q     = sq;
    bus.i_sample_ctrl  = c;
    bus.i_sample_valid = 1'b1;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk);
      if (bus.o_sample_ready) begin
        acc = 1'b1;
        exp_q.push_back(model_frame(si, sq, c));
      end
      tick();
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    // busy must not drop before the last tail frame has been pushed
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("idle_state", 32'(dbg), 32'd0);
    tick();
  endtask

  task automatic end_burst();
    bus.i_sample_valid = 1'b0;
    tx_en = 1'b0;
    for (int k = 0; k < TAIL; k++) exp_q.push_back(32'h8000_4000);
    wait_idle();
  endtask

  initial begin
    int          base;
    bit          got;
    logic [12:0] si, sq;
    logic        sc;

    rst = 1'b1;
    tx_en = 1'b0;
    bus.i_sample_i = '0;
    bus.i_sample_q = '0;
    bus.i_sample_ctrl = 1'b0;
    bus.i_sample_valid = 1'b0;
    bus.i_fifo_full = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_push", 32'(bus.o_fifo_push), 32'd0);
    chk("rst_ready", 32'(bus.o_sample_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg), 32'd0);
    chk("rst_data", bus.o_fifo_data, 32'h8000_4000);
    tick();
    rst = 1'b0;
    tick();

    // Basic burst: 2 preamble, 3 samples, 2 tail = 7 pushes.
    base = push_cnt;
    start_burst();
    for (int i = 0; i < 3; i++) send_sample(13'h0001, 13'h1FFF, 1'b0, 0);
    end_burst();
    chk("basic_push_count", 32'(push_cnt - base), 32'd7);

    // Ctrl marker bit: expected per build.
    start_burst();
    send_sample(13'h0AAA, 13'h1555, 1'b1, 0);
    send_sample(13'h1000, 13'h0FFF, 1'b0, 0);
    end_burst();

    // Throughput: valid held, 100 consecutive accepting/pushing cycles.
    start_burst();
    si = 13'($urandom); sq = 13'($urandom); sc = 1'($urandom);
    bus.i_sample_i = si; bus.i_sample_q = sq; bus.i_sample_ctrl = sc;
    bus.i_sample_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.o_sample_ready) got = 1'b1;
      else tick();
    end
    if (!got) chk("tput_start_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 100; i++) begin
      chk("tput_ready", 32'(bus.o_sample_ready), 32'd1);
      chk("tput_push", 32'(bus.o_fifo_push), 32'd1);
      chk("tput_state", 32'(dbg), 32'd2);
      exp_q.push_back(model_frame(si, sq, sc));
      tick();
      if (i < 99) begin
        si = 13'($urandom); sq = 13'($urandom); sc = 1'($urandom);
        bus.i_sample_i = si; bus.i_sample_q = sq; bus.i_sample_ctrl = sc;
        @(negedge clk);
      end
    end
    end_burst();

    // Backpressure mid-stream for 5 cycles.
    start_burst();
    for (int i = 0; i < 3; i++) send_sample(13'(i + 5), 13'(i + 9), 1'b0, 0);
    bus.i_fifo_full = 1'b1;
    bus.i_sample_i = 13'h0123; bus.i_sample_q = 13'h1321; bus.i_sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_push", 32'(bus.o_fifo_push), 32'd0);
      chk("bp_ready", 32'(bus.o_sample_ready), 32'd0);
      tick();
    end
    bus.i_fifo_full = 1'b0;
    send_sample(13'h0123, 13'h1321, 1'b0, 0);
    send_sample(13'h1FFF, 13'h0000, 1'b1, 0);
    end_burst();

    // FIFO full when the burst ends: tail waits for full to drop.
    start_burst();
    send_sample(13'h0042, 13'h0024, 1'b0, 0);
    send_sample(13'h0043, 13'h0025, 1'b0, 0);
    bus.i_fifo_full = 1'b1;
    bus.i_sample_valid = 1'b0;
    tx_en = 1'b0;
    for (int k = 0; k < TAIL; k++) exp_q.push_back(32'h8000_4000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("endfull_push", 32'(bus.o_fifo_push), 32'd0);
      chk("endfull_busy", 32'(busy), 32'd1);
      tick();
    end
    bus.i_fifo_full = 1'b0;
    wait_idle();

    // Random bursts with random FIFO backpressure.
    rand_full = 1'b1;
    for (int b = 0; b < 6; b++) begin
      int n;
      n = int'($urandom_range(1, 20));
      start_burst();
      for (int i = 0; i < n; i++)
        send_sample(13'($urandom), 13'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end_burst();
    end
    rand_full = 1'b0;
    tick();
    bus.i_fifo_full = 1'b0;

    // Reset mid-stream while a word is held.
    start_burst();
    send_sample(13'h0777, 13'h0888, 1'b0, 0);
    send_sample(13'h0999, 13'h0AAA, 1'b0, 0);
    bus.i_fifo_full = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_push", 32'(bus.o_fifo_push), 32'd0);
    chk("midrst_ready", 32'(bus.o_sample_ready), 32'd0);
    tick();
    rst = 1'b0;
    tx_en = 1'b0;
    bus.i_sample_valid = 1'b0;
    bus.i_fifo_full = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("postrst_state", 32'(dbg), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_ready", 32'(bus.o_sample_ready), 32'd0);
    chk("postrst_push", 32'(bus.o_fifo_push), 32'd0);
    tick();
    base = push_cnt;
    start_burst();
    send_sample(13'h0002, 13'h0003, 1'b1, 0);
    end_burst();
    chk("restart_push_count", 32'(push_cnt - base), 32'(PRE + 1 + TAIL));

    repeat (3) tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
